// File: rtl/gpr_if.sv
// Register-file port bundle: read ports, write port, issue/scoreboard port and write trace.
// There is no valid/ready handshake here: WE and issue_en are plain per-cycle qualifiers, sampled on every rising edge.
interface gpr_if #(parameter int DATA_W = 32);
  logic [4:0]        RA1;
  logic [4:0]        RA2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              WE;
  logic [4:0]        WA;
  logic [DATA_W-1:0] WD;
  logic [31:0]       PC;
  logic              issue_en;
  logic [4:0]        issue_addr;
  logic              busy1;
  logic              busy2;
  logic              trace_valid;
  logic [4:0]        trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [31:0]       trace_pc;
  logic [31:0]       wr_count;

  modport master (
    output RA1, RA2, WE, WA, WD, PC, issue_en, issue_addr,
    input  RD1, RD2, busy1, busy2, trace_valid, trace_addr, trace_data, trace_pc, wr_count
  );

  modport slave (
    input  RA1, RA2, WE, WA, WD, PC, issue_en, issue_addr,
    output RD1, RD2, busy1, busy2, trace_valid, trace_addr, trace_data, trace_pc, wr_count
  );
endinterface

// File: rtl/gpr_file.sv
// 31 x DATA_W general-purpose registers ($0 hardwired to zero) with two combinational
// read ports, optional write bypass, a pending-write scoreboard and a registered write trace.
module gpr_file #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic  clk,
  input  logic  reset,
  gpr_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [1:31];
  logic [DATA_W-1:0] regs_d [1:31];
  logic [31:1]       busy_q, busy_d;
  logic              trace_valid_q, trace_valid_d;
  logic [4:0]        trace_addr_q, trace_addr_d;
  logic [DATA_W-1:0] trace_data_q, trace_data_d;
  logic [31:0]       trace_pc_q, trace_pc_d;
  logic [31:0]       wr_count_q, wr_count_d;

  logic              commit;
  logic              hit1, hit2;
  logic [31:0]       busy_full;
  logic [DATA_W-1:0] rd1, rd2;

  assign commit    = bus.WE && (bus.WA != 5'd0);
  assign busy_full = {busy_q, 1'b0};

  // A forwarded write also masks busy: the consumer already has the data.
  assign hit1 = (BYPASS != 0) && bus.WE && (bus.WA == bus.RA1) && (bus.RA1 != 5'd0);
  assign hit2 = (BYPASS != 0) && bus.WE && (bus.WA == bus.RA2) && (bus.RA2 != 5'd0);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.RA1 == 5'(i)) rd1 = regs_q[i];
      if (bus.RA2 == 5'(i)) rd2 = regs_q[i];
    end
    if (hit1) rd1 = bus.WD;
    if (hit2) rd2 = bus.WD;
  end

  assign bus.RD1   = rd1;
  assign bus.RD2   = rd2;
  assign bus.busy1 = busy_full[bus.RA1] && !hit1;
  assign bus.busy2 = busy_full[bus.RA2] && !hit2;

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      if (commit && (bus.WA == 5'(i))) begin
        regs_d[i] = bus.WD;
        busy_d[i] = 1'b0;
      end
      // Set after clear: a same-cycle issue is a newer pending write.
      if (bus.issue_en && (bus.issue_addr == 5'(i))) busy_d[i] = 1'b1;
    end
  end

  always_comb begin
    trace_valid_d = commit;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    trace_pc_d    = trace_pc_q;
    wr_count_d    = wr_count_q;
    if (commit) begin
      trace_addr_d = bus.WA;
      trace_data_d = bus.WD;
      trace_pc_d   = bus.PC;
      if (wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      busy_q        <= '0;
      trace_valid_q <= 1'b0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
      trace_pc_q    <= '0;
      wr_count_q    <= '0;
    end else begin
      for (int i = 1; i < 32; i++) regs_q[i] <= regs_d[i];
      busy_q        <= busy_d;
      trace_valid_q <= trace_valid_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
      trace_pc_q    <= trace_pc_d;
      wr_count_q    <= wr_count_d;
    end
  end

  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_addr  = trace_addr_q;
  assign bus.trace_data  = trace_data_q;
  assign bus.trace_pc    = trace_pc_q;
  assign bus.wr_count    = wr_count_q;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: per-feature tasks, a reference model of regs/busy/count,
// and a trace scoreboard queue filled at commit and drained on trace_valid.
module tb_gpr_file;
  localparam int DATA_W = 32;
  localparam int BYP    = 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  gpr_if #(.DATA_W(DATA_W)) bus ();

  gpr_file #(.DATA_W(DATA_W), .BYPASS(BYP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [68:0]       exp_q [$];
  logic [DATA_W-1:0] m_regs [32];
  logic              m_busy [32];
  logic [31:0]       m_count;

  task automatic idle();
    bus.WE         = 1'b0;
    bus.WA         = 5'd0;
    bus.WD         = '0;
    bus.PC         = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = 5'd0;
  endtask

  // One rising edge: update the model, then check trace and count after the edge.
  task automatic tick();
    logic        c;
    logic [68:0] e;
    c = !reset && bus.WE && (bus.WA != 5'd0);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_count = '0;
      exp_q.delete();
    end else begin
      if (c) begin
        exp_q.push_back({bus.WA, bus.WD, bus.PC});
        m_regs[bus.WA] = bus.WD;
        m_busy[bus.WA] = 1'b0;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
      end
      if (bus.issue_en && bus.issue_addr != 5'd0) m_busy[bus.issue_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.trace_valid !== c) begin
      failures++;
      $display("FAIL trace_valid: got %b expected %b", bus.trace_valid, c);
    end
    if (bus.trace_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL trace_unexpected: got addr %0d with empty queue", bus.trace_addr);
      end else begin
        e = exp_q.pop_front();
        if ({bus.trace_addr, bus.trace_data, bus.trace_pc} !== e) begin
          failures++;
          $display("FAIL trace_entry: got %h/%h/%h expected %h/%h/%h", bus.trace_addr,
                   bus.trace_data, bus.trace_pc, e[68:64], e[63:32], e[31:0]);
        end
      end
    end
    checks++;
    if (bus.wr_count !== m_count) begin
      failures++;
      $display("FAIL wr_count: got %0d expected %0d", bus.wr_count, m_count);
    end
  endtask

  task automatic test_reset();
    idle();
    bus.RA1 = 5'd0;
    bus.RA2 = 5'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.RA1 = 5'(a);
      bus.RA2 = 5'(31 - a);
      #1;
      checks++;
      if (bus.RD1 !== '0 || bus.RD2 !== '0 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_read a=%0d: got rd1=%h rd2=%h b1=%b b2=%b expected zeros",
                 a, bus.RD1, bus.RD2, bus.busy1, bus.busy2);
      end
    end
    checks++;
    if (bus.trace_addr !== 5'd0 || bus.trace_data !== '0 || bus.trace_pc !== '0) begin
      failures++;
      $display("FAIL reset_trace: got %h/%h/%h expected 0/0/0", bus.trace_addr,
               bus.trace_data, bus.trace_pc);
    end
  endtask

  task automatic test_write_bypass();
    logic [DATA_W-1:0] exp_rd;
    bus.WE  = 1'b1;
    bus.WA  = 5'd5;
    bus.WD  = 32'hDEAD_BEEF;
    bus.PC  = 32'h0000_3000;
    bus.RA1 = 5'd5;
    #1;
    exp_rd = (BYP != 0) ? 32'hDEAD_BEEF : 32'h0;
    checks++;
    if (bus.RD1 !== exp_rd) begin
      failures++;
      $display("FAIL bypass_rd1: got %h expected %h", bus.RD1, exp_rd);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.RD1 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL stored_rd1: got %h expected deadbeef", bus.RD1);
    end
    checks++;
    if (bus.trace_addr !== 5'd5 || bus.trace_data !== 32'hDEAD_BEEF ||
        bus.trace_pc !== 32'h0000_3000 || bus.wr_count !== 32'd1) begin
      failures++;
      $display("FAIL first_trace: got %h/%h/%h cnt=%0d expected 05/deadbeef/00003000 cnt=1",
               bus.trace_addr, bus.trace_data, bus.trace_pc, bus.wr_count);
    end
  endtask

  task automatic test_write_zero();
    bus.WE  = 1'b1;
    bus.WA  = 5'd0;
    bus.WD  = 32'h1234_5678;
    bus.RA1 = 5'd0;
    #1;
    checks++;
    if (bus.RD1 !== '0) begin
      failures++;
      $display("FAIL zero_bypass: got %h expected 0", bus.RD1);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.RD1 !== '0 || bus.wr_count !== 32'd1) begin
      failures++;
      $display("FAIL zero_write: got rd1=%h cnt=%0d expected 0 cnt=1", bus.RD1, bus.wr_count);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_b;
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'd8;
    bus.RA1        = 5'd8;
    bus.RA2        = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy1 !== 1'b1) begin
      failures++;
      $display("FAIL busy_set: got %b expected 1", bus.busy1);
    end
    // Write 8 and re-issue 8, plus issue nothing to 9 yet.
    bus.WE = 1'b1; bus.WA = 5'd8; bus.WD = 32'hA5A5_0008; bus.PC = 32'h100;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd8;
    #1;
    exp_b = (BYP != 0) ? 1'b0 : 1'b1;
    checks++;
    if (bus.busy1 !== exp_b) begin
      failures++;
      $display("FAIL busy_mask: got %b expected %b", bus.busy1, exp_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy1 !== 1'b1) begin
      failures++;
      $display("FAIL busy_set_wins: got %b expected 1", bus.busy1);
    end
    // Clear 8 while issuing 9: both take effect.
    bus.WE = 1'b1; bus.WA = 5'd8; bus.WD = 32'h0000_0808; bus.PC = 32'h104;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b1) begin
      failures++;
      $display("FAIL busy_clear: got b1=%b b2=%b expected b1=0 b2=1", bus.busy1, bus.busy2);
    end
  endtask

  task automatic test_reset_mid();
    bus.WE = 1'b1; bus.WA = 5'd3; bus.WD = 32'd7; bus.PC = 32'h200;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    bus.RA1 = 5'd3;
    bus.RA2 = 5'd9;
    #1;
    checks++;
    if (bus.RD1 !== '0 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0 || bus.wr_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: got rd1=%h b1=%b b2=%b cnt=%0d expected all 0",
               bus.RD1, bus.busy1, bus.busy2, bus.wr_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a <= 3; a++) begin
      bus.WE = 1'b1;
      bus.WA = 5'(a);
      bus.WD = $urandom;
      bus.PC = 32'h400 + 32'(4 * a);
      tick();
    end
    idle();
    checks++;
    if (bus.wr_count !== 32'd3) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 3", bus.wr_count);
    end
    tick();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] e1, e2;
    logic              eb1, eb2;
    for (int n = 0; n < 60; n++) begin
      bus.WE         = ($urandom_range(0, 3) != 0);
      bus.WA         = 5'($urandom_range(0, 7));
      bus.WD         = $urandom;
      bus.PC         = $urandom;
      bus.issue_en   = ($urandom_range(0, 1) != 0);
      bus.issue_addr = 5'($urandom_range(0, 7));
      bus.RA1        = 5'($urandom_range(0, 7));
      bus.RA2        = 5'($urandom_range(0, 7));
      #1;
      e1  = (bus.RA1 == 0) ? '0 : m_regs[bus.RA1];
      e2  = (bus.RA2 == 0) ? '0 : m_regs[bus.RA2];
      eb1 = (bus.RA1 != 0) && m_busy[bus.RA1];
      eb2 = (bus.RA2 != 0) && m_busy[bus.RA2];
      if (BYP != 0 && bus.WE && bus.RA1 != 0 && bus.WA == bus.RA1) begin e1 = bus.WD; eb1 = 1'b0; end
      if (BYP != 0 && bus.WE && bus.RA2 != 0 && bus.WA == bus.RA2) begin e2 = bus.WD; eb2 = 1'b0; end
      checks++;
      if (bus.RD1 !== e1 || bus.RD2 !== e2 || bus.busy1 !== eb1 || bus.busy2 !== eb2) begin
        failures++;
        $display("FAIL random_read n=%0d: got %h %h %b %b expected %h %h %b %b", n,
                 bus.RD1, bus.RD2, bus.busy1, bus.busy2, e1, e2, eb1, eb2);
      end
      tick();
    end
    idle();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL trace_drain: got %0d leftover entries expected 0", exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    m_count  = '0;
    idle();
    bus.RA1 = 5'd0;
    bus.RA2 = 5'd0;
    test_reset();
    test_write_bypass();
    test_write_zero();
    test_scoreboard();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
# gpr_file

General-purpose register file for the MIPS datapath: the read-side and storage end of the register write path whose address (rt / rd / $31) and data (ALU result / memory data / PC+4) are selected upstream. Holds 32 x 32-bit registers with $0 hardwired to zero. Provides two combinational read ports with optional same-cycle write bypass, and a pending-write scoreboard for the pipelined core. Provides a registered write-trace port for the bench and the console log.

## Interface
- DATA_W, 32, register width
- BYPASS, 1, 1 = read ports return WD when a write to the same nonzero address is in progress this cycle
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- RA1  in  5  read address, port 1
- RA2  in  5  read address, port 2
- RD1  out  DATA_W  read data, port 1 (combinational)
- RD2  out  DATA_W  read data, port 2 (combinational)
- WE  in  1  write enable
- WA  in  5  write address
- WD  in  DATA_W  write data
- PC  in  32  PC of the writing instruction (trace only)
- issue_en  in  1  mark a register as pending
- issue_addr  in  5  register to mark pending
- busy1  out  1  RA1 has a pending write (combinational)
- busy2  out  1  RA2 has a pending write (combinational)
- trace_valid  out  1  a write committed on the previous edge
- trace_addr  out  5  address of that write
- trace_data  out  DATA_W  data of that write
- trace_pc  out  32  PC of that write
- wr_count  out  32  committed nonzero-address writes since reset

## Operation
- Storage: regs[1..31]. regs[0] does not exist; reads of address 0 return 0 and busy of address 0 is 0.
- Write: on an edge with WE=1, WA!=0 and reset=0, regs[WA] <= WD. WE with WA=0 is discarded: no storage change, no trace, no count.
- Read: RDn = 0 if RAn=0. Otherwise, if BYPASS=1, WE=1 and WA=RAn, RDn = WD. Otherwise RDn = regs[RAn]. With BYPASS=0, a same-cycle write is visible only after the edge.
- Scoreboard: busy[31:1] bits.
  - issue_en=1 with issue_addr!=0 sets busy[issue_addr].
  - A committed write clears busy[WA].
  - If an issue and a write target the same address in one cycle, set wins, because it is a newer pending write.
  - Issues and writes to different addresses both take effect.
- busy outputs: busyn = busy[RAn] for RAn!=0. When BYPASS=1 and the current cycle writes RAn, busyn = 0, because the data is already forwarded.
- Trace: on every edge, trace_valid <= committed write this edge. When trace_valid is set, trace_addr/data/pc <= WA/WD/PC. When trace_valid is 0, trace_addr/data/pc hold their previous values.
- wr_count increments by 1 per committed write and saturates at 0xFFFFFFFF.

## Timing
- Reset, sampled at the rising edge, has priority over write and issue in the same cycle.
- Reset clears all regs, all busy bits, wr_count, trace_valid, trace_addr, trace_data and trace_pc to 0.
- After reset: RD1=RD2=0, busy1=busy2=0.
- Write latency: 1 edge to storage. 0 cycles to read ports with BYPASS=1.
- Trace latency: 1 edge. trace_valid is a single-cycle pulse per write, high for consecutive cycles under back-to-back writes.
- Scoreboard: a set or clear is visible on busyn the cycle after the edge, apart from the combinational bypass masking described above.
- Reset mid-operation discards that cycle's write and issue. Pending bits are lost, and the core must flush on reset.
- All reads are purely combinational from RA, WE, WA and WD. There is no read enable.

## Test plan
- Reset, then read all 32 addresses on both ports -> every RD = 0, busy = 0, wr_count = 0, trace_valid = 0.
- Write WA=5, WD=0xDEADBEEF, PC=0x00003000. Same cycle, RA1=5 -> RD1=0xDEADBEEF with BYPASS=1, 0 with BYPASS=0. After the edge, RD1=0xDEADBEEF, trace_valid=1 with trace_addr=5, trace_data=0xDEADBEEF, trace_pc=0x00003000, and wr_count=1.
- Write WA=0, WD=0x12345678 -> RD of address 0 stays 0, trace_valid stays 0, wr_count unchanged.
- Issue addr 8 -> next cycle busy1=1 for RA1=8. Then write WA=8 together with issue_addr=8 -> busy stays 1. Then write WA=8 with no issue -> busy1=0 after the edge.
- Hold reset=1 while WE=1, WA=3, WD=7 and issue_addr=3 -> after the edge, regs[3]=0, busy[3]=0, trace_valid=0.
- Perform 3 back-to-back writes to addresses 1, 2, 3 -> trace_valid high for 3 consecutive cycles with matching trace_addr, and wr_count=3.
